// File: rtl/subservient_sram_arbiter_pkg.sv
// Shared types for the two-port Wishbone to byte-wide SRAM arbiter.
// Holds the FSM encoding, the byte counter width and the byte lane selector.
package subservient_sram_arbiter_pkg;

  localparam int CNT_W   = 2;
  localparam int SRAM_AW = 10;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RLAST,
    ACK
  } state_t;

  function automatic logic [7:0] byte_of(input logic [31:0] word,
                                         input logic [CNT_W-1:0] k);
    return word[8*k +: 8];
  endfunction

endpackage

// File: rtl/subservient_rr_arb.sv
// Two-requester round-robin arbiter; remembers the last grant so ties alternate.
module subservient_rr_arb (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic       o_valid,
  output logic       o_gnt
);

  logic last_q;

  // A lone requester always wins; on a tie the one not granted last goes first.
  always_comb begin
    o_valid = |i_req;
    o_gnt   = i_req[1];
    if (i_req == 2'b11) o_gnt = ~last_q;
  end

  // Resetting to 1 lets requester 0 take the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              last_q <= 1'b1;
    else if (i_en && o_valid)  last_q <= o_gnt;
  end

endmodule

// File: rtl/subservient_sram_arbiter.sv
// Shares one byte-wide SRAM between two 32-bit Wishbone ports.
// Each access is split into four sequential byte cycles; SRAM outputs are registered.
module subservient_sram_arbiter
  import subservient_sram_arbiter_pkg::*;
#(
  parameter int memsize = 1024
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [$clog2(memsize)-3:0]     i_wb_r0_adr,
  input  logic [31:0]                    i_wb_r0_dat,
  input  logic [3:0]                     i_wb_r0_sel,
  input  logic                           i_wb_r0_we,
  input  logic                           i_wb_r0_stb,
  output logic [31:0]                    o_wb_r0_rdt,
  output logic                           o_wb_r0_ack,
  input  logic [$clog2(memsize)-3:0]     i_wb_r1_adr,
  input  logic [31:0]                    i_wb_r1_dat,
  input  logic [3:0]                     i_wb_r1_sel,
  input  logic                           i_wb_r1_we,
  input  logic                           i_wb_r1_stb,
  output logic [31:0]                    o_wb_r1_rdt,
  output logic                           o_wb_r1_ack,
  output logic [SRAM_AW-1:0]             o_sram_waddr,
  output logic [7:0]                     o_sram_wdata,
  output logic                           o_sram_wen,
  output logic [SRAM_AW-1:0]             o_sram_raddr,
  input  logic [7:0]                     i_sram_rdata
);

  localparam int aw = $clog2(memsize);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic             gnt_q;
  logic [aw-3:0]    adr_q;
  logic [31:0]      dat_q;
  logic [3:0]       sel_q;
  logic [23:0]      rbuf_q;
  logic [31:0]      rdt_q;

  logic             arb_valid, arb_gnt;
  logic [aw-3:0]    req_adr;
  logic [31:0]      req_dat;
  logic [3:0]       req_sel;
  logic             req_we;

  function automatic logic [SRAM_AW-1:0] byte_addr(input logic [aw-3:0] a,
                                                   input logic [CNT_W-1:0] k);
    return SRAM_AW'({a, k});
  endfunction

  subservient_rr_arb u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (state_q == IDLE),
    .i_req   ({i_wb_r1_stb, i_wb_r0_stb}),
    .o_valid (arb_valid),
    .o_gnt   (arb_gnt)
  );

  assign req_adr = arb_gnt ? i_wb_r1_adr : i_wb_r0_adr;
  assign req_dat = arb_gnt ? i_wb_r1_dat : i_wb_r0_dat;
  assign req_sel = arb_gnt ? i_wb_r1_sel : i_wb_r0_sel;
  assign req_we  = arb_gnt ? i_wb_r1_we  : i_wb_r0_we;
  assign cnt_nxt = cnt_q + 2'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // RLAST is the extra cycle needed to catch the last byte's one-cycle read latency.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_valid) state_d = req_we ? WRITE : READ;
      WRITE:   if (cnt_q == 2'd3) state_d = ACK;
      READ:    if (cnt_q == 2'd3) state_d = RLAST;
      RLAST:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM controls are loaded one cycle ahead so byte k appears in cycle T+1+k.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q        <= '0;
      gnt_q        <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      sel_q        <= '0;
      rbuf_q       <= '0;
      rdt_q        <= '0;
      o_sram_waddr <= '0;
      o_sram_wdata <= '0;
      o_sram_wen   <= 1'b0;
      o_sram_raddr <= '0;
    end else begin
      o_sram_wen <= 1'b0;
      case (state_q)
        IDLE: if (arb_valid) begin
          gnt_q <= arb_gnt;
          adr_q <= req_adr;
          dat_q <= req_dat;
          sel_q <= req_sel;
          if (req_we) begin
            o_sram_waddr <= byte_addr(req_adr, 2'd0);
            o_sram_wdata <= req_dat[7:0];
            o_sram_wen   <= req_sel[0];
          end else begin
            o_sram_raddr <= byte_addr(req_adr, 2'd0);
          end
        end
        WRITE: begin
          cnt_q <= cnt_nxt;
          if (cnt_q != 2'd3) begin
            o_sram_waddr <= byte_addr(adr_q, cnt_nxt);
            o_sram_wdata <= byte_of(dat_q, cnt_nxt);
            o_sram_wen   <= sel_q[cnt_nxt];
          end
        end
        READ: begin
          cnt_q <= cnt_nxt;
          if (cnt_q != 2'd3) o_sram_raddr <= byte_addr(adr_q, cnt_nxt);
          case (cnt_q)
            2'd1:    rbuf_q[7:0]   <= i_sram_rdata;
            2'd2:    rbuf_q[15:8]  <= i_sram_rdata;
            2'd3:    rbuf_q[23:16] <= i_sram_rdata;
            default: ;
          endcase
        end
        // Visible rdt only changes once the whole word is in, so it holds between reads.
        RLAST: rdt_q <= {i_sram_rdata, rbuf_q};
        default: ;
      endcase
    end
  end

  assign o_wb_r0_ack = (state_q == ACK) && !gnt_q;
  assign o_wb_r1_ack = (state_q == ACK) &&  gnt_q;
  assign o_wb_r0_rdt = rdt_q;
  assign o_wb_r1_rdt = rdt_q;

endmodule

// File: doc/subservient_sram_arbiter.md
SUBSERVIENT_SRAM_ARBITER -- requirements
Module: subservient_sram_arbiter

Interface
REQ-001 SHALL have parameter memsize, default 1024, meaning SRAM size in bytes; aw = $clog2(memsize), aw <= 10.
REQ-002 SHALL have port i_clk  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports i_wb_rN_adr  in  aw-2  word address, for N=0,1.
REQ-005 SHALL have ports i_wb_rN_dat  in  32  write data, for N=0,1.
REQ-006 SHALL have ports i_wb_rN_sel  in  4  byte enables, for N=0,1.
REQ-007 SHALL have ports i_wb_rN_we  in  1  write when 1, for N=0,1.
REQ-008 SHALL have ports i_wb_rN_stb  in  1  request, held until ack, for N=0,1.
REQ-009 SHALL have ports o_wb_rN_rdt  out  32  read data, for N=0,1.
REQ-010 SHALL have ports o_wb_rN_ack  out  1  one-cycle completion, for N=0,1.
REQ-011 SHALL have SRAM ports o_sram_waddr out 10, o_sram_wdata out 8, o_sram_wen out 1, o_sram_raddr out 10, i_sram_rdata in 8; read data valid the cycle after raddr is presented.

Function
REQ-012 SHALL arbitrate in IDLE only: sample both stb in cycle T; grant if any is high; at most one grant at a time.
REQ-013 SHALL use round-robin on simultaneous requests: grant the requester not granted last; a single requester always wins.
REQ-014 SHALL latch adr/dat/sel/we of the granted requester in cycle T; later input changes ignored.
REQ-015 Write: state WRITE cycles T+1..T+4 present byte k (k=0..3) at address {adr,k}, data dat[8k+7:8k], o_sram_wen=sel[k].
REQ-016 Write: o_wb_rN_ack high in cycle T+5 (state ACK); IDLE from T+6.
REQ-017 Read: state READ cycles T+1..T+4 present o_sram_raddr={adr,k}; capture i_sram_rdata into rdt byte k in cycles T+2..T+5.
REQ-018 Read: ack high in cycle T+6 with full 32-bit o_wb_rN_rdt valid; IDLE from T+7.
REQ-019 SHALL keep o_sram_wen low in all states except WRITE; o_sram_waddr/wdata/raddr hold their last value when idle.
REQ-020 SHALL drive only the granted requester's ack; both rdt outputs carry the same assembled register, held until the next read completes.
REQ-021 sel=4'b0000 write: no wen pulses, still 5-cycle ack.
REQ-022 Read ignores sel; all four bytes read.
REQ-023 stb dropped mid-transaction: transaction completes, ack still issued (protocol violation, no abort).
REQ-024 stb still high in the cycle after ack: treated as a new request (classic Wishbone, master deasserts on ack).
REQ-025 Byte address {adr,k} SHALL be zero-extended to 10 bits; no wrap logic.

Reset
REQ-026 While i_rst_n=0: state IDLE, all acks 0, o_sram_wen 0, addresses/wdata 0, rdt 0, last-grant=1 (so requester 0 wins first tie).
REQ-027 Reset mid-transaction SHALL abort immediately (o_sram_wen low asynchronously); no ack issued for the aborted request.
REQ-028 First grant possible in the first cycle after i_rst_n deasserts.

Structure
REQ-029 State encodings (IDLE, WRITE, READ, RLAST, ACK) and byte-count width SHALL live in shared package subservient_sram_arbiter_pkg.
REQ-030 Round-robin grant logic SHALL be one sub-module subservient_rr_arb (2 requesters, last-grant register inside).
REQ-031 Byte counter 2 bits, wraps 3->0 on leaving WRITE/READ.

Verification
REQ-032 r0 write adr=0x05, dat=0xA1B2C3D4, sel=0xF -> wen cycles T+1..T+4 at waddr 0x14..0x17 with D4,C3,B2,A1; r0 ack at T+5.
REQ-033 Preload 0x20..0x23 = 11,22,33,44; r1 read adr=0x08 -> raddr 0x20..0x23 T+1..T+4; r1 ack T+6, rdt=0x44332211.
REQ-034 Both stb high from reset release -> r0 granted first, r1 granted on IDLE after r0 ack; repeat -> strict alternation.
REQ-035 r0 write sel=4'b0101 -> wen high only at bytes 0 and 2; ack at T+5.
REQ-036 Assert i_rst_n=0 at T+2 of a write -> wen low same cycle, no ack, IDLE after release; next request served normally.
